// File: rtl/ysyx_22041071_id_stage_p.sv
// Decode/issue stage: register file with write-through, operand forwarding or
// stall-only hazard handling, and a registered operand bundle toward EX.
module ysyx_22041071_id_stage_p #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_ins,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            uses_rs1,
  input  logic            uses_rs2,
  input  logic            rd_we,
  input  logic            is_load,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      src1_sel,
  input  logic [1:0]      src2_sel,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_src_a,
  output logic [XLEN-1:0] out_src_b,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_is_load,
  output logic [31:0]     hazard_cnt,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] r_rf [NREG];
  logic [XLEN:0]   w_res1;
  logic [XLEN:0]   w_res2;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_src_b;
  logic            w_hazard;
  logic            w_out_free;
  logic            w_wr_en;

  assign w_wr_en = wb_we && (wb_rd != 5'd0) && (int'(wb_rd) < NREG);

  // Regfile read with same-cycle write-through of the WB port.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NREG) return '0;
    if (wb_we && wb_rd == idx) return wb_data;
    return r_rf[idx[AW-1:0]];
  endfunction

  // Returns {hazard, value} for one source operand.
  function automatic logic [XLEN:0] resolve(input logic [4:0] idx, input logic used);
    logic            haz;
    logic [XLEN-1:0] val;
    haz = 1'b0;
    val = rf_read(idx);
    if (FWD_EN != 0) begin
      if (ex_we && ex_rd == idx && idx != 5'd0) begin
        if (ex_is_load) haz = used;
        else            val = ex_data;
      end else if (mem_we && mem_rd == idx && idx != 5'd0) begin
        val = mem_data;
      end else if (wb_we && wb_rd == idx && idx != 5'd0) begin
        val = wb_data;
      end
    end else begin
      if (used && idx != 5'd0 &&
          ((ex_we && ex_rd == idx) || (mem_we && mem_rd == idx)))
        haz = 1'b1;
    end
    return {haz, val};
  endfunction

  always_comb begin
    w_res1 = resolve(rs1, uses_rs1);
    w_res2 = resolve(rs2, uses_rs2);
  end

  always_comb begin
    w_src_a = '0;
    case (src1_sel)
      2'd0:    w_src_a = w_res1[XLEN-1:0];
      2'd1:    w_src_a = in_pc;
      default: w_src_a = '0;
    endcase
  end

  always_comb begin
    w_src_b = '0;
    case (src2_sel)
      2'd0:    w_src_b = w_res2[XLEN-1:0];
      2'd1:    w_src_b = imm;
      2'd2:    w_src_b = XLEN'(4);
      default: w_src_b = '0;
    endcase
  end

  // A flushed instruction is dropped, so it never counts as a stall.
  assign w_hazard   = in_valid && (w_res1[XLEN] || w_res2[XLEN]) && !flush;
  assign w_out_free = !out_valid || out_ready;
  assign in_ready   = !reset && w_out_free && !w_hazard && !flush;

  assign dbg_data = (dbg_addr == 5'd0 || int'(dbg_addr) >= NREG) ? '0
                                                                 : r_rf[dbg_addr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wr_en) begin
      r_rf[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_ins      <= '0;
      out_src_a    <= '0;
      out_src_b    <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_is_load  <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (w_out_free) begin
      if (in_valid && !w_hazard) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_ins      <= in_ins;
        out_src_a    <= w_src_a;
        out_src_b    <= w_src_b;
        out_rs2_data <= w_res2[XLEN-1:0];
        out_rd       <= rd;
        out_rd_we    <= rd_we;
        out_is_load  <= is_load;
      end else begin
        out_valid   <= 1'b0;
        out_rd_we   <= 1'b0;
        out_is_load <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             hazard_cnt <= '0;
    else if (w_hazard && hazard_cnt != '1) hazard_cnt <= hazard_cnt + 32'd1;
  end

endmodule

// File: tb/tb_ysyx_22041071_id_stage_p.sv
// Directed bench: forwarding instance (defaults) and a stall-only NREG=16
// instance share all stimulus; each check compares against hand-derived values.
module tb_ysyx_22041071_id_stage_p;
  logic        clk = 0;
  logic        reset, in_valid, uses_rs1, uses_rs2, rd_we, is_load;
  logic [63:0] in_pc, imm, ex_data, mem_data, wb_data;
  logic [31:0] in_ins;
  logic [4:0]  rs1, rs2, rd, ex_rd, mem_rd, wb_rd, dbg_addr;
  logic [1:0]  src1_sel, src2_sel;
  logic        ex_we, ex_is_load, mem_we, wb_we, flush, out_ready;

  logic        in_ready, out_valid, out_rd_we, out_is_load;
  logic [63:0] out_pc, out_src_a, out_src_b, out_rs2_data, dbg_data;
  logic [31:0] out_ins, hazard_cnt;
  logic [4:0]  out_rd;

  logic        in_ready_0, out_valid_0, out_rd_we_0, out_is_load_0;
  logic [63:0] out_pc_0, out_src_a_0, out_src_b_0, out_rs2_data_0, dbg_data_0;
  logic [31:0] out_ins_0, hazard_cnt_0;
  logic [4:0]  out_rd_0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ysyx_22041071_id_stage_p dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd_we(rd_we), .is_load(is_load),
    .imm(imm), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .hazard_cnt(hazard_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  ysyx_22041071_id_stage_p #(.XLEN(64), .NREG(16), .FWD_EN(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_0),
    .in_pc(in_pc), .in_ins(in_ins), .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .rd_we(rd_we), .is_load(is_load),
    .imm(imm), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_pc(out_pc_0), .out_ins(out_ins_0),
    .out_src_a(out_src_a_0), .out_src_b(out_src_b_0), .out_rs2_data(out_rs2_data_0),
    .out_rd(out_rd_0), .out_rd_we(out_rd_we_0), .out_is_load(out_is_load_0),
    .hazard_cnt(hazard_cnt_0), .dbg_addr(dbg_addr), .dbg_data(dbg_data_0)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [1:0]  s1, s2;
    logic        exw, exl;
    logic [4:0]  exrd;
    logic [63:0] exd;
    logic        mw;
    logic [4:0]  mrd;
    logic [63:0] md;
    logic        ww;
    logic [4:0]  wrd;
    logic [63:0] wd;
    logic        rdy;
    logic [63:0] a, b, r2;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; uses_rs1 = 0; uses_rs2 = 0; rd_we = 0; is_load = 0;
    in_pc = 64'h1000; in_ins = 32'h13; imm = 64'h7;
    rs1 = 0; rs2 = 0; rd = 0; src1_sel = 0; src2_sel = 0;
    ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1; dbg_addr = 0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
    idle();
    wb_we = 1; wb_rd = r; wb_data = d;
    tick();
    idle();
  endtask

  // Load-use: EX holds a load to x7 and the instruction reads rs2=x7.
  task automatic load_use_inputs();
    idle();
    in_valid = 1; uses_rs2 = 1; rs2 = 7; rd = 9; rd_we = 1;
    ex_we = 1; ex_is_load = 1; ex_rd = 7;
  endtask

  initial begin
    vec[0] = '{5'd1, 5'd2, 1, 1, 2'd0, 2'd0, 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
               1, 64'h11, 64'h22, 64'h22};
    vec[1] = '{5'd5, 5'd0, 1, 0, 2'd0, 2'd1, 1, 0, 5'd5, 64'h10, 1, 5'd5, 64'h20, 0, 5'd0, 64'h0,
               1, 64'h10, 64'h7, 64'h0};
    vec[2] = '{5'd2, 5'd1, 1, 1, 2'd0, 2'd2, 0, 0, 5'd0, 64'h0, 1, 5'd2, 64'h20, 1, 5'd2, 64'h30,
               1, 64'h20, 64'h4, 64'h11};
    vec[3] = '{5'd1, 5'd6, 1, 1, 2'd2, 2'd0, 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 5'd6, 64'h66,
               1, 64'h0, 64'h66, 64'h66};
    vec[4] = '{5'd0, 5'd2, 1, 1, 2'd0, 2'd0, 1, 0, 5'd0, 64'h99, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
               1, 64'h0, 64'h30, 64'h30};
    vec[5] = '{5'd1, 5'd1, 1, 1, 2'd3, 2'd3, 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
               1, 64'h0, 64'h0, 64'h11};
    vec[6] = '{5'd1, 5'd2, 0, 0, 2'd1, 2'd1, 1, 1, 5'd1, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
               1, 64'h1000, 64'h7, 64'h30};
    vec[7] = '{5'd1, 5'd6, 1, 1, 2'd0, 2'd0, 0, 0, 5'd1, 64'hEE, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
               1, 64'h11, 64'h66, 64'h66};

    idle();
    reset = 1;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hazard_cnt", hazard_cnt, 0);
    chk("rst_out_src_a", out_src_a, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_dbg_data", dbg_data, 0);
    reset = 0;

    wb_write(5'd1, 64'h11);
    wb_write(5'd2, 64'h22);
    wb_write(5'd5, 64'h1);
    dbg_addr = 5; #1;
    chk("preload_x5", dbg_data, 64'h1);

    for (int i = 0; i < 8; i++) begin
      idle();
      in_valid = 1; rd = 5'(i + 8); rd_we = 1; in_ins = 32'h13 + i;
      rs1 = vec[i].rs1; rs2 = vec[i].rs2; uses_rs1 = vec[i].u1; uses_rs2 = vec[i].u2;
      src1_sel = vec[i].s1; src2_sel = vec[i].s2;
      ex_we = vec[i].exw; ex_is_load = vec[i].exl; ex_rd = vec[i].exrd; ex_data = vec[i].exd;
      mem_we = vec[i].mw; mem_rd = vec[i].mrd; mem_data = vec[i].md;
      wb_we = vec[i].ww; wb_rd = vec[i].wrd; wb_data = vec[i].wd;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vec[i].rdy);
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_src_a", i), out_src_a, vec[i].a);
      chk($sformatf("v%0d_src_b", i), out_src_b, vec[i].b);
      chk($sformatf("v%0d_rs2_data", i), out_rs2_data, vec[i].r2);
      chk($sformatf("v%0d_out_rd", i), out_rd, 64'(i + 8));
      if (i == 0) chk("v0_out_ins", out_ins, 64'h13);
    end
    chk("table_hazard_cnt", hazard_cnt, 0);

    load_use_inputs();
    #1;
    chk("lu_in_ready", in_ready, 0);
    tick();
    chk("lu_bubble_valid", out_valid, 0);
    chk("lu_bubble_rd_we", out_rd_we, 0);
    chk("lu_hazard_cnt", hazard_cnt, 1);
    idle();
    in_valid = 1; uses_rs2 = 1; rs2 = 7; rd = 9; rd_we = 1;
    mem_we = 1; mem_rd = 7; mem_data = 64'h55;
    #1;
    chk("lu2_in_ready", in_ready, 1);
    tick();
    chk("lu2_out_valid", out_valid, 1);
    chk("lu2_rs2_data", out_rs2_data, 64'h55);
    chk("lu2_rd_we", out_rd_we, 1);
    chk("lu2_hazard_cnt", hazard_cnt, 1);

    idle();
    in_valid = 1; uses_rs1 = 1; rs1 = 1; ex_we = 1; ex_rd = 1; ex_data = 64'hA1;
    tick();
    chk("bp_load_a", out_src_a, 64'hA1);
    for (int k = 0; k < 3; k++) begin
      out_ready = 0; ex_data = 64'hB0 + 64'(k); rs1 = 1; in_pc = 64'h2000;
      #1;
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      tick();
      chk($sformatf("bp%0d_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_src_a", k), out_src_a, 64'hA1);
      chk($sformatf("bp%0d_pc", k), out_pc, 64'h1000);
    end
    out_ready = 1; ex_data = 64'hB3;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_release_a", out_src_a, 64'hB3);

    load_use_inputs();
    flush = 1;
    #1;
    chk("fl_stall_ready", in_ready, 0);
    tick();
    chk("fl_stall_valid", out_valid, 0);
    chk("fl_stall_hcnt", hazard_cnt, 1);
    idle();
    in_valid = 1; uses_rs1 = 1; rs1 = 1; flush = 1;
    #1;
    chk("fl_load_ready", in_ready, 0);
    tick();
    chk("fl_load_valid", out_valid, 0);

    idle();
    in_valid = 1; rd = 3; rd_we = 1;
    tick();
    chk("rs_pre_valid", out_valid, 1);
    load_use_inputs();
    out_ready = 0;
    tick();
    chk("rs_stall_hcnt", hazard_cnt, 2);
    reset = 1; wb_we = 1; wb_rd = 4; wb_data = 64'h44;
    #1;
    chk("rs_in_ready", in_ready, 0);
    tick();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_rd_we", out_rd_we, 0);
    chk("rs_hazard_cnt", hazard_cnt, 0);
    chk("rs0_hazard_cnt", hazard_cnt_0, 0);
    reset = 0;
    idle();
    dbg_addr = 4; #1;
    chk("rs_no_wb_write", dbg_data, 0);

    wb_write(5'd0, 64'hFF);
    wb_write(5'd20, 64'h77);
    dbg_addr = 0; #1;
    chk("x0_zero", dbg_data, 0);
    dbg_addr = 20; #1;
    chk("x20_nreg32", dbg_data, 64'h77);
    chk("x20_nreg16", dbg_data_0, 0);
    idle();
    in_valid = 1; uses_rs1 = 1; rs1 = 20;
    #1;
    chk("b16_in_ready", in_ready_0, 1);
    tick();
    chk("b16_src_a", out_src_a_0, 0);
    chk("b32_src_a", out_src_a, 64'h77);

    idle();
    in_valid = 1; uses_rs1 = 1; rs1 = 3; wb_we = 1; wb_rd = 3; wb_data = 64'hABCD;
    #1;
    chk("wt_in_ready0", in_ready_0, 1);
    tick();
    chk("wt_src_a0", out_src_a_0, 64'hABCD);
    idle();
    dbg_addr = 3; #1;
    chk("wt_dbg0", dbg_data_0, 64'hABCD);
    in_valid = 1; uses_rs1 = 1; rs1 = 3; ex_we = 1; ex_rd = 3; ex_data = 64'h1;
    #1;
    chk("so_in_ready0", in_ready_0, 0);
    chk("so_in_ready_fwd", in_ready, 1);
    tick();
    chk("so_valid0", out_valid_0, 0);
    chk("so_hcnt0", hazard_cnt_0, 1);
    chk("so_src_a_fwd", out_src_a, 64'h1);

    idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
